fifo_storage: RTL and testbench

Data-path stage directly downstream of the FIFO control_module. Consumes write_signal/read_signal and the 3-bit write_addr/read_addr that control_module produces. Holds an 8-entry register-file memory, registers read data out, and keeps its own occupancy count. Generates full/empty flags and accept strobes, which the upstream logic uses to gate its requests.

---
 rtl/fifo_storage_if.sv | 36 +++
 rtl/fifo_storage.sv | 117 +++++++++++
 tb/tb_fifo_storage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_storage_if.sv
// Handshake/data bundle between the FIFO control path and fifo_storage.
// master: upstream side (drives requests, pointers, write data).
// slave : fifo_storage (returns read data, acks, occupancy and flags).
interface fifo_storage_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) ();

  logic                  write_signal;
  logic                  read_signal;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  wr_ack;
  logic                  rd_ack;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output write_signal, read_signal, write_addr, read_addr, data_in,
    input  data_out, data_valid, wr_ack, rd_ack, count, full, empty,
           overflow, underflow
  );

  modport slave (
    input  write_signal, read_signal, write_addr, read_addr, data_in,
    output data_out, data_valid, wr_ack, rd_ack, count, full, empty,
           overflow, underflow
  );

endinterface

// File: rtl/fifo_storage.sv
// fifo_storage: 2**ADDR_WIDTH-entry register-file memory behind the FIFO
// control path. Stores accepted writes, returns registered read data with
// one cycle of latency, tracks its own occupancy and decodes full/empty.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-low reset
//   bus  - fifo_storage_if.slave: write_signal/read_signal, write_addr/
//          read_addr, data_in in; data_out, data_valid, wr_ack, rd_ack,
//          count, full, empty, overflow, underflow out.
//
// Optional feature macro: FIFO_STORAGE_ERR_FLAG_EN
//   defined   - sticky overflow/underflow flags, cleared only by rst
//   undefined - overflow/underflow tied to 0
module fifo_storage #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic          clk,
  input  logic          rst,
  fifo_storage_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  full_c, empty_c, wr_ack_c, rd_ack_c;

  // Flags decode from the registered count only, so they are glitch-free.
  always_comb begin
    full_c   = (count_q == CNT_W'(DEPTH));
    empty_c  = (count_q == CNT_W'(0));
    wr_ack_c = bus.write_signal & ~full_c;
    rd_ack_c = bus.read_signal & ~empty_c;
  end

  // Next-state for count and read port; read sees the pre-edge word,
  // giving read-before-write when both hit the same address.
  always_comb begin
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    case ({wr_ack_c, rd_ack_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (rd_ack_c) begin
      data_out_d   = mem_q[bus.read_addr];
      data_valid_d = 1'b1;
    end
  end

  // Control/read registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Storage array; rejected writes leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ack_c) begin
      mem_q[bus.write_addr] <= bus.data_in;
    end
  end

`ifdef FIFO_STORAGE_ERR_FLAG_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error flags: any request against a full/empty store.
  always_comb begin
    overflow_d  = overflow_q | (bus.write_signal & full_c);
    underflow_d = underflow_q | (bus.read_signal & empty_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.count      = count_q;
  assign bus.full       = full_c;
  assign bus.empty      = empty_c;
  assign bus.wr_ack     = wr_ack_c;
  assign bus.rd_ack     = rd_ack_c;

endmodule

// File: tb/tb_fifo_storage.sv
// Self-checking bench for fifo_storage: reference model with a read-data
// scoreboard, a constant-expectation vector table for fill/drain, and
// hand-written sequences for simultaneous access, wrap and mid-op reset.
module tb_fifo_storage;

`ifdef FIFO_STORAGE_ERR_FLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  fifo_storage_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  fifo_storage #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       w;
    logic       r;
    logic [2:0] wa;
    logic [2:0] ra;
    logic [7:0] din;
    logic [3:0] e_count;
    logic       e_full;
    logic       e_empty;
    logic       e_dv;
    logic [7:0] e_dout;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state.
  logic [7:0] mem_m [8];
  int         cnt_m;
  logic [7:0] dout_m;
  logic       ovf_m, unf_m;
  logic [7:0] sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
    cnt_m  = 0;
    dout_m = 8'h00;
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
    sb_q.delete();
  endtask

  task automatic idle_inputs();
    bus.write_signal = 1'b0;
    bus.read_signal  = 1'b0;
    bus.write_addr   = 3'd0;
    bus.read_addr    = 3'd0;
    bus.data_in      = 8'h00;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_count"}, 32'(bus.count), 32'd0);
    check({tag, "_empty"}, 32'(bus.empty), 32'd1);
    check({tag, "_full"}, 32'(bus.full), 32'd0);
    check({tag, "_dv"}, 32'(bus.data_valid), 32'd0);
    check({tag, "_dout"}, 32'(bus.data_out), 32'd0);
    check({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    check({tag, "_unf"}, 32'(bus.underflow), 32'd0);
  endtask

  // Reset for 15 ns with random requests toggling, then release off-edge.
  task automatic do_reset();
    rst = 1'b0;
    bus.write_signal = 1'($urandom_range(0, 1));
    bus.read_signal  = 1'($urandom_range(0, 1));
    bus.write_addr   = 3'($urandom_range(0, 7));
    bus.read_addr    = 3'($urandom_range(0, 7));
    bus.data_in      = 8'($urandom_range(0, 255));
    #12;
    check_reset_vals("reset");
    #3;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus: model predicts, then acks and registered outputs compared.
  task automatic cycle(input logic w, input logic r, input logic [2:0] wa,
                       input logic [2:0] ra, input logic [7:0] din);
    logic full_m, empty_m, wok, rok;
    bus.write_signal = w;
    bus.read_signal  = r;
    bus.write_addr   = wa;
    bus.read_addr    = ra;
    bus.data_in      = din;
    full_m  = (cnt_m == 8);
    empty_m = (cnt_m == 0);
    wok = w & ~full_m;
    rok = r & ~empty_m;
    #1;
    check("wr_ack", 32'(bus.wr_ack), 32'(wok));
    check("rd_ack", 32'(bus.rd_ack), 32'(rok));
    if (rok) sb_q.push_back(mem_m[ra]);
    if (ERR_EN && w && full_m) ovf_m = 1'b1;
    if (ERR_EN && r && empty_m) unf_m = 1'b1;
    if (wok) mem_m[wa] = din;
    cnt_m = cnt_m + int'(wok) - int'(rok);
    @(posedge clk);
    #1;
    check("count", 32'(bus.count), 32'(cnt_m));
    check("full", 32'(bus.full), 32'(cnt_m == 8));
    check("empty", 32'(bus.empty), 32'(cnt_m == 0));
    check("data_valid", 32'(bus.data_valid), 32'(rok));
    if (rok && sb_q.size() > 0) dout_m = sb_q.pop_front();
    check("data_out", 32'(bus.data_out), 32'(dout_m));
    check("overflow", 32'(bus.overflow), 32'(ovf_m));
    check("underflow", 32'(bus.underflow), 32'(unf_m));
  endtask

  initial begin
    vec_t vecs [18];

    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{w: 1'b1, r: 1'b0, wa: 3'(i), ra: 3'd0, din: 8'(8'h10 + i),
                  e_count: 4'(i + 1), e_full: (i == 7), e_empty: 1'b0,
                  e_dv: 1'b0, e_dout: 8'h00};
    end
    vecs[8] = '{w: 1'b1, r: 1'b0, wa: 3'd0, ra: 3'd0, din: 8'hFF,
                e_count: 4'd8, e_full: 1'b1, e_empty: 1'b0, e_dv: 1'b0, e_dout: 8'h00};
    for (int i = 0; i < 8; i++) begin
      vecs[9 + i] = '{w: 1'b0, r: 1'b1, wa: 3'd0, ra: 3'(i), din: 8'h00,
                      e_count: 4'(7 - i), e_full: 1'b0, e_empty: (i == 7),
                      e_dv: 1'b1, e_dout: 8'(8'h10 + i)};
    end
    vecs[17] = '{w: 1'b0, r: 1'b1, wa: 3'd0, ra: 3'd0, din: 8'h00,
                 e_count: 4'd0, e_full: 1'b0, e_empty: 1'b1, e_dv: 1'b0, e_dout: 8'h17};

    do_reset();

    // Post-reset memory reads zero at addresses 0..6 (count held at 1 via addr 7).
    cycle(1'b1, 1'b0, 3'd7, 3'd0, 8'h5A);
    for (int a = 0; a < 7; a++) begin
      cycle(1'b1, 1'b1, 3'd7, 3'(a), 8'h5A);
      check("zero_after_reset", 32'(bus.data_out), 32'd0);
    end
    cycle(1'b0, 1'b1, 3'd0, 3'd7, 8'h00);
    // Second reset must also clear the written word at address 7.
    do_reset();
    cycle(1'b1, 1'b0, 3'd0, 3'd0, 8'hC3);
    cycle(1'b1, 1'b1, 3'd0, 3'd7, 8'hC3);
    check("zero_after_reset_a7", 32'(bus.data_out), 32'd0);

    // Fill / overfill / drain / underflow from the constant table.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(vecs[i].w, vecs[i].r, vecs[i].wa, vecs[i].ra, vecs[i].din);
      check("vec_count", 32'(bus.count), 32'(vecs[i].e_count));
      check("vec_full", 32'(bus.full), 32'(vecs[i].e_full));
      check("vec_empty", 32'(bus.empty), 32'(vecs[i].e_empty));
      check("vec_dv", 32'(bus.data_valid), 32'(vecs[i].e_dv));
      check("vec_dout", 32'(bus.data_out), 32'(vecs[i].e_dout));
    end
    check("ovf_after_fill", 32'(bus.overflow), 32'(ERR_EN));
    check("unf_after_drain", 32'(bus.underflow), 32'(ERR_EN));

    // Simultaneous access at count=3.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 3'(i), 3'd0, 8'(8'h30 + i));
    cycle(1'b1, 1'b1, 3'd3, 3'd0, 8'hAA);
    check("sim3_count", 32'(bus.count), 32'd3);
    check("sim3_dout", 32'(bus.data_out), 32'h30);
    cycle(1'b0, 1'b1, 3'd0, 3'd1, 8'h00);
    cycle(1'b0, 1'b1, 3'd0, 3'd2, 8'h00);
    cycle(1'b0, 1'b1, 3'd0, 3'd3, 8'h00);
    check("sim3_mem3", 32'(bus.data_out), 32'hAA);

    // Simultaneous access at full: write dropped.
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 3'(i), 3'd0, 8'(8'h40 + i));
    cycle(1'b1, 1'b1, 3'd0, 3'd0, 8'hFF);
    check("simfull_count", 32'(bus.count), 32'd7);
    check("simfull_dout", 32'(bus.data_out), 32'h40);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 3'd0, 3'(i), 8'h00);
    check("simfull_nowrite", 32'(bus.count), 32'd0);

    // Simultaneous access at empty: read rejected.
    cycle(1'b1, 1'b1, 3'd0, 3'd0, 8'h55);
    check("simempty_count", 32'(bus.count), 32'd1);
    check("simempty_dv", 32'(bus.data_valid), 32'd0);
    // Same-address read/write returns the old word.
    cycle(1'b1, 1'b1, 3'd0, 3'd0, 8'h66);
    check("rbw_old", 32'(bus.data_out), 32'h55);
    cycle(1'b0, 1'b1, 3'd0, 3'd0, 8'h00);
    check("rbw_new", 32'(bus.data_out), 32'h66);

    // Wrap-around: 12 writes across the 7->0 boundary, read back in order.
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 3'(k), 3'd0, 8'(8'h20 + k));
    for (int k = 4; k < 12; k++) begin
      cycle(1'b1, 1'b1, 3'(k % 8), 3'((k - 4) % 8), 8'(8'h20 + k));
      check("wrap_mid", 32'(bus.data_out), 32'(8'h20 + k - 4));
    end
    for (int k = 8; k < 12; k++) begin
      cycle(1'b0, 1'b1, 3'd0, 3'(k % 8), 8'h00);
      check("wrap_tail", 32'(bus.data_out), 32'(8'h20 + k));
    end

    // Mid-operation reset while a read result is valid.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 3'((i + 4) % 8), 3'd0, 8'(8'h60 + i));
    cycle(1'b0, 1'b1, 3'd0, 3'd4, 8'h00);
    check("midrst_pre_dv", 32'(bus.data_valid), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_vals("midrst");
    #5;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b1, 3'd0, 3'd0, 8'h00);
    check("post_rst_unf", 32'(bus.underflow), 32'(ERR_EN));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
